// File: rtl/gpio_fifo_pkg.sv
// GPIO serial-to-FIFO bridge shared types.
// Bit map of the PS EMIO GPIO bus and the FSM state type.
package gpio_fifo_pkg;

   localparam int unsigned GPIO_SCLK  = 0;
   localparam int unsigned GPIO_SDATA = 1;
   localparam int unsigned GPIO_WRITE = 2;
   localparam int unsigned GPIO_RSTPL = 3;
   localparam int unsigned GPIO_CLR   = 4;
   localparam int unsigned GPIO_SEL   = 5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT_LOW
   } state_t;

   function automatic int unsigned ch_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gpio_serial_fifo_bridge_if.sv
// FIFO-side bundle of the GPIO serial bridge.
// master drives the word bus and strobes; slave returns full flags.
interface gpio_serial_fifo_bridge_if #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4
) ();

   logic [NUM_CH-1:0] fifo_full;
   logic [DATA_W-1:0] fifo_dout;
   logic [NUM_CH-1:0] fifo_wr_en;

   modport master (
      input  fifo_full,
      output fifo_dout,
      output fifo_wr_en
   );

   modport slave (
      output fifo_full,
      input  fifo_dout,
      input  fifo_wr_en
   );

endinterface

// File: rtl/gpio_sync.sv
// Multi-bit synchroniser with registered rising-edge detect.
// Edges are masked until the chain holds only post-reset samples.
module gpio_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise
);

   logic [W-1:0]    s [STAGES];
   logic [W-1:0]    q_d;
   logic [STAGES:0] vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) s[i] <= '0;
         q_d  <= '0;
         vld  <= '0;
         rise <= '0;
      end else begin
         s[0] <= d;
         for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
         q_d  <= s[STAGES-1];
         vld  <= {vld[STAGES-1:0], 1'b1};
         // a bit already high at release is never seen as an edge
         rise <= vld[STAGES] ? (s[STAGES-1] & ~q_d) : '0;
      end
   end

   assign q = s[STAGES-1];

endmodule

// File: rtl/gpio_serial_fifo_bridge.sv
// Bit-banged GPIO serial receiver that commits words to one of
// NUM_CH FIFOs, with sticky overflow and framing error flags.
module gpio_serial_fifo_bridge
   import gpio_fifo_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [31:0]                emio_gpio_i,
   output logic                       rst_pl,
   gpio_serial_fifo_bridge_if.master  fifo,
   output logic [NUM_CH-1:0]          overflow,
   output logic                       frame_err
);

   localparam int CH_W  = ch_bits(NUM_CH);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

   logic [2:0]      e_q;
   logic [2:0]      e_rise;
   logic [CH_W+1:0] l_q;
   logic [CH_W+1:0] l_rise;

   gpio_sync #(.W(3), .STAGES(SYNC_STAGES)) u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    ({emio_gpio_i[GPIO_CLR],
              emio_gpio_i[GPIO_WRITE],
              emio_gpio_i[GPIO_SCLK]}),
      .q    (e_q),
      .rise (e_rise)
   );

   gpio_sync #(.W(CH_W+2), .STAGES(SYNC_STAGES)) u_lvl (
      .clk  (clk),
      .rst  (rst),
      .d    ({emio_gpio_i[GPIO_SEL +: CH_W],
              emio_gpio_i[GPIO_RSTPL],
              emio_gpio_i[GPIO_SDATA]}),
      .q    (l_q),
      .rise (l_rise)
   );

   logic            sclk_rise;
   logic            wr_rise;
   logic            wr_lvl;
   logic            clr;
   logic            sdata;
   logic [CH_W-1:0] sel;

   assign sclk_rise = e_rise[0];
   assign wr_rise   = e_rise[1];
   assign wr_lvl    = e_q[1];
   assign clr       = e_q[2];
   assign sdata     = l_q[0];
   assign rst_pl    = l_q[1];
   assign sel       = l_q[2 +: CH_W];

   wire unused_sync = &{1'b0, e_q[0], e_rise[2], l_rise,
                        emio_gpio_i[31:GPIO_SEL+CH_W]};

   state_t              state, state_n;
   logic [CNT_W-1:0]    bit_cnt, cnt_n;
   logic [DATA_W-1:0]   shreg, sh_n;
   logic [DATA_W-1:0]   dout_q, dout_n;
   logic [NUM_CH-1:0]   wen_q, wen_n;
   logic [NUM_CH-1:0]   ovf_q, ovf_n;
   logic                err_q, err_n;
   logic [NUM_CH-1:0]   hit;
   logic                full_sel;
   logic [NUM_CH-1:0]   set_ovf;
   logic                set_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
         dout_q  <= '0;
         wen_q   <= '0;
         ovf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= cnt_n;
         shreg   <= sh_n;
         dout_q  <= dout_n;
         wen_q   <= wen_n;
         ovf_q   <= ovf_n;
         err_q   <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = bit_cnt;
      sh_n     = shreg;
      dout_n   = dout_q;
      wen_n    = '0;
      set_ovf  = '0;
      set_err  = 1'b0;
      hit      = '0;
      full_sel = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel == CH_W'(i)) begin
            hit[i]   = 1'b1;
            full_sel = fifo.fifo_full[i];
         end
      end
      // a write wins over a coincident sclk, whose bit is dropped
      if (wr_rise) begin
         cnt_n   = '0;
         state_n = WAIT_LOW;
         if (sclk_rise) set_err = 1'b1;
         if (hit == '0 || bit_cnt != CNT_MAX) begin
            set_err = 1'b1;
         end else if (full_sel) begin
            set_ovf = hit;
         end else begin
            wen_n  = hit;
            dout_n = shreg;
         end
      end else if (sclk_rise) begin
         if (state == WAIT_LOW) begin
            set_err = 1'b1;
         end else begin
            sh_n    = DATA_W'({shreg, sdata});
            state_n = SHIFT;
            if (bit_cnt == CNT_MAX) set_err = 1'b1;
            else cnt_n = bit_cnt + CNT_W'(1);
         end
      end else if (state == WAIT_LOW && !wr_lvl) begin
         state_n = IDLE;
      end
      ovf_n = (clr ? '0 : ovf_q) | set_ovf;
      err_n = (clr ? 1'b0 : err_q) | set_err;
   end

   assign fifo.fifo_dout  = dout_q;
   assign fifo.fifo_wr_en = wen_q;
   assign overflow        = ovf_q;
   assign frame_err       = err_q;

endmodule

// File: tb/tb_gpio_serial_fifo_bridge.sv
// Directed bench for gpio_serial_fifo_bridge.
// Bit-bangs words over the GPIO bus and checks strobes and flags.
module tb_gpio_serial_fifo_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] gpio = '0;
   logic        rst_pl;
   logic [3:0]  overflow;
   logic        frame_err;

   int n_cmp = 0;
   int n_bad = 0;
   int strobe_total = 0;

   gpio_serial_fifo_bridge_if #(.DATA_W(32), .NUM_CH(4)) fif ();

   gpio_serial_fifo_bridge #(
      .DATA_W      (32),
      .NUM_CH      (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .emio_gpio_i (gpio),
      .rst_pl      (rst_pl),
      .fifo        (fif.master),
      .overflow    (overflow),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (fif.fifo_wr_en != '0) strobe_total++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [63:0] data, input int nb);
      for (int i = nb - 1; i >= 0; i--) begin
         gpio[1] = data[i];
         tick(3);
         gpio[0] = 1'b1;
         tick(3);
         gpio[0] = 1'b0;
         tick(3);
      end
   endtask

   task automatic do_write(input int ch, input bit with_sclk,
                           output int n, output logic [3:0] val,
                           output int first);
      logic [1:0] c;
      c = 2'(ch);
      gpio[6:5] = c;
      tick(4);
      n = 0;
      val = '0;
      first = 0;
      gpio[2] = 1'b1;
      if (with_sclk) gpio[0] = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         if (fif.fifo_wr_en != '0) begin
            n++;
            val = fif.fifo_wr_en;
            if (first == 0) first = i;
         end
      end
      gpio[2] = 1'b0;
      gpio[0] = 1'b0;
      tick(6);
   endtask

   task automatic clr_pulse();
      gpio[4] = 1'b1;
      tick(4);
      gpio[4] = 1'b0;
      tick(4);
   endtask

   int         n;
   int         first;
   int         snap;
   logic [3:0] val;

   initial begin
      fif.fifo_full = '0;
      // sclk and write already high while in reset
      gpio = 32'h0000_0005;
      tick(5);
      chk("rst_wr_en", 64'(fif.fifo_wr_en), 64'h0);
      chk("rst_dout", 64'(fif.fifo_dout), 64'h0);
      chk("rst_ovf", 64'(overflow), 64'h0);
      chk("rst_ferr", 64'(frame_err), 64'h0);
      chk("rst_rst_pl", 64'(rst_pl), 64'h0);
      rst = 1'b1;
      tick(10);
      chk("rel_no_edge_err", 64'(frame_err), 64'h0);
      chk("rel_no_strobe", 64'(strobe_total), 64'h0);
      gpio = '0;
      tick(6);

      gpio[3] = 1'b1;
      tick(4);
      chk("rst_pl_hi", 64'(rst_pl), 64'h1);
      gpio[3] = 1'b0;
      tick(4);
      chk("rst_pl_lo", 64'(rst_pl), 64'h0);

      send_bits(64'hDEAD_BEEF, 32);
      do_write(2, 1'b0, n, val, first);
      chk("w2_count", 64'(n), 64'd1);
      chk("w2_wr_en", 64'(val), 64'h4);
      chk("w2_latency", 64'(first), 64'd4);
      chk("w2_dout", 64'(fif.fifo_dout), 64'hDEAD_BEEF);
      chk("w2_ovf", 64'(overflow), 64'h0);
      chk("w2_ferr", 64'(frame_err), 64'h0);

      fif.fifo_full = 4'b0010;
      send_bits(64'h1234_5678, 32);
      do_write(1, 1'b0, n, val, first);
      chk("full_count", 64'(n), 64'd0);
      chk("full_ovf", 64'(overflow), 64'h2);
      chk("full_dout", 64'(fif.fifo_dout), 64'hDEAD_BEEF);
      chk("full_ferr", 64'(frame_err), 64'h0);
      fif.fifo_full = '0;
      clr_pulse();
      chk("clr_ovf", 64'(overflow), 64'h0);

      send_bits(64'h1357_9BDF, 31);
      do_write(0, 1'b0, n, val, first);
      chk("short_count", 64'(n), 64'd0);
      chk("short_ferr", 64'(frame_err), 64'h1);
      chk("short_dout", 64'(fif.fifo_dout), 64'hDEAD_BEEF);
      clr_pulse();
      chk("clr_ferr", 64'(frame_err), 64'h0);
      send_bits(64'hA5A5_0F0F, 32);
      do_write(0, 1'b0, n, val, first);
      chk("w0_count", 64'(n), 64'd1);
      chk("w0_wr_en", 64'(val), 64'h1);
      chk("w0_dout", 64'(fif.fifo_dout), 64'hA5A5_0F0F);
      chk("w0_ferr", 64'(frame_err), 64'h0);

      send_bits(64'hCAFE_F00D, 32);
      gpio[1] = 1'b1;
      do_write(1, 1'b1, n, val, first);
      chk("coin_count", 64'(n), 64'd1);
      chk("coin_wr_en", 64'(val), 64'h2);
      chk("coin_dout", 64'(fif.fifo_dout), 64'hCAFE_F00D);
      chk("coin_ferr", 64'(frame_err), 64'h1);
      clr_pulse();

      send_bits(64'h1_0000_00FF, 33);
      chk("sat_ferr", 64'(frame_err), 64'h1);
      do_write(0, 1'b0, n, val, first);
      chk("sat_count", 64'(n), 64'd1);
      chk("sat_dout", 64'(fif.fifo_dout), 64'h0000_00FF);
      clr_pulse();
      chk("sat_clr", 64'(frame_err), 64'h0);

      send_bits(64'hFFFF, 16);
      gpio[6:5] = 2'd3;
      gpio[2] = 1'b1;
      rst = 1'b0;
      tick(2);
      chk("mid_rst_dout", 64'(fif.fifo_dout), 64'h0);
      chk("mid_rst_wr_en", 64'(fif.fifo_wr_en), 64'h0);
      gpio = '0;
      snap = strobe_total;
      tick(2);
      rst = 1'b1;
      tick(10);
      chk("stray_strobe", 64'(strobe_total - snap), 64'd0);
      send_bits(64'h0000_0001, 32);
      do_write(3, 1'b0, n, val, first);
      chk("w3_count", 64'(n), 64'd1);
      chk("w3_wr_en", 64'(val), 64'h8);
      chk("w3_dout", 64'(fif.fifo_dout), 64'h0000_0001);
      chk("w3_ferr", 64'(frame_err), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
